// File: rtl/ptos_lane_sched.sv
// Lane scheduler for the IDLE-capable parallel-to-serial stage.
// It trains the lane with a COM burst, round-robins two byte requesters per 8-bit slot, and shifts symbols out MSB-first.
module ptos_lane_sched #(
    parameter logic [7:0]  IDLE_SYM   = 8'h7C,
    parameter logic [7:0]  COM_SYM    = 8'hBC,
    parameter int unsigned SYNC_COUNT = 4
) (
    input  logic       clk32f,
    input  logic       reset,
    input  logic       valid_0,
    input  logic [7:0] data_0,
    input  logic       valid_1,
    input  logic [7:0] data_1,
    output logic       ack_0,
    output logic       ack_1,
    output logic       out,
    output logic       active,
    output logic       sym_start,
    output logic [1:0] lane_sel
);

    localparam int unsigned SYM_W  = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned SYNC_W = 4;

    localparam logic [1:0] SEL_NONE  = 2'b00;
    localparam logic [1:0] SEL_LANE0 = 2'b01;
    localparam logic [1:0] SEL_LANE1 = 2'b10;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_q;
    logic [SYNC_W-1:0]  sync_cnt_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic               first_q;
    logic [SYM_W-1:0]   shreg_q;
    logic               rr_q;
    logic               sym_start_q;
    logic               ack_0_q;
    logic               ack_1_q;
    logic [1:0]         lane_sel_q;
    logic               active_q;

    logic               load_c;
    logic               run_c;
    logic [SYM_W-1:0]   sym_d;
    logic [1:0]         sel_d;
    logic               grant_0_d;
    logic               grant_1_d;
    logic               rr_d;

    // A slot boundary is the last bit of a symbol, or the very first edge out of reset.
    assign load_c = first_q || (bit_cnt_q == CNT_W'(0));
    // The load that follows the last COM symbol already belongs to RUN.
    assign run_c  = (state_q == ST_RUN) || (sync_cnt_q == SYNC_W'(SYNC_COUNT));

    // Next-symbol selection and round-robin arbitration for the upcoming slot.
    always_comb begin
        sym_d     = IDLE_SYM;
        sel_d     = SEL_NONE;
        grant_0_d = 1'b0;
        grant_1_d = 1'b0;
        rr_d      = rr_q;
        if (!run_c) begin
            sym_d = COM_SYM;
        end else if (valid_0 && valid_1) begin
            grant_0_d = ~rr_q;
            grant_1_d = rr_q;
        end else begin
            grant_0_d = valid_0;
            grant_1_d = valid_1;
        end
        if (grant_0_d) begin
            sym_d = data_0;
            sel_d = SEL_LANE0;
            rr_d  = 1'b1;
        end else if (grant_1_d) begin
            sym_d = data_1;
            sel_d = SEL_LANE1;
            rr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk32f) begin
        if (reset) begin
            state_q     <= ST_SYNC;
            sync_cnt_q  <= '0;
            bit_cnt_q   <= CNT_W'(7);
            first_q     <= 1'b1;
            shreg_q     <= '0;
            rr_q        <= 1'b0;
            sym_start_q <= 1'b0;
            ack_0_q     <= 1'b0;
            ack_1_q     <= 1'b0;
            lane_sel_q  <= SEL_NONE;
            active_q    <= 1'b0;
        end else if (load_c) begin
            first_q     <= 1'b0;
            bit_cnt_q   <= CNT_W'(7);
            shreg_q     <= sym_d;
            sym_start_q <= 1'b1;
            lane_sel_q  <= sel_d;
            ack_0_q     <= grant_0_d;
            ack_1_q     <= grant_1_d;
            rr_q        <= rr_d;
            if (run_c) begin
                state_q  <= ST_RUN;
                active_q <= 1'b1;
            end else begin
                sync_cnt_q <= sync_cnt_q + SYNC_W'(1);
            end
        end else begin
            bit_cnt_q   <= bit_cnt_q - CNT_W'(1);
            shreg_q     <= {shreg_q[SYM_W-2:0], 1'b0};
            sym_start_q <= 1'b0;
            ack_0_q     <= 1'b0;
            ack_1_q     <= 1'b0;
        end
    end

    assign out       = shreg_q[SYM_W-1];
    assign sym_start = sym_start_q;
    assign ack_0     = ack_0_q;
    assign ack_1     = ack_1_q;
    assign lane_sel  = lane_sel_q;
    assign active    = active_q;

endmodule
